// File: rtl/microc_ctrl.sv
// Control unit for the single-cycle microcontroller: opcode decode, RUN/HALT/TRAP FSM and
// optional saturating performance counters (enabled by defining MICROC_CTRL_PERF_EN).
module microc_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             halted,
  output logic             trap,
  output logic [CNT_W-1:0] ins_count,
  output logic [CNT_W-1:0] jmp_count
);

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_HALT = 2'b01;
  localparam logic [1:0] ST_TRAP = 2'b10;

  logic [1:0] r_state;
  logic       r_halted;
  logic       r_trap;

  logic w_run;
  logic w_nop, w_li, w_alu, w_j, w_jz, w_jnz, w_halt, w_legal;
  logic w_jmp_taken;

  assign w_run   = (r_state == ST_RUN);
  assign w_nop   = (Opcode == 6'b000000);
  assign w_li    = (Opcode[5:2] == 4'b0001);
  assign w_alu   = (Opcode[5:3] == 3'b001);
  assign w_j     = (Opcode == 6'b010000);
  assign w_jz    = (Opcode == 6'b010001);
  assign w_jnz   = (Opcode == 6'b010010);
  assign w_halt  = (Opcode == 6'b010011);
  assign w_legal = w_nop | w_li | w_alu | w_j | w_jz | w_jnz | w_halt;

  assign w_jmp_taken = w_run & (w_j | (w_jz & z) | (w_jnz & ~z));

  // Reset forces a harmless PC+1 with no writes; HALT/illegal/non-RUN gate writes and load the jump address.
  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    Op    = 3'b000;
    if (reset) begin
      if (!w_run || w_halt || !w_legal) begin
        s_inc = 1'b0;
      end else if (w_li) begin
        s_inm = 1'b1;
        we3   = 1'b1;
      end else if (w_alu) begin
        we3   = 1'b1;
        wez   = 1'b1;
        Op    = Opcode[2:0];
      end else if (w_j || w_jz || w_jnz) begin
        s_inc = ~w_jmp_taken;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
      r_trap   <= 1'b0;
    end else if (w_run) begin
      if (w_halt) begin
        r_state  <= ST_HALT;
        r_halted <= 1'b1;
      end else if (!w_legal) begin
        r_state  <= ST_TRAP;
        r_trap   <= 1'b1;
      end
    end
  end

  assign halted = r_halted;
  assign trap   = r_trap;

`ifdef MICROC_CTRL_PERF_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_ins_count;
  logic [CNT_W-1:0] r_jmp_count;

  assign w_retire = w_run & w_legal & ~w_halt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ins_count <= '0;
      r_jmp_count <= '0;
    end else begin
      if (w_retire && (r_ins_count != '1))
        r_ins_count <= r_ins_count + 1'b1;
      if (w_jmp_taken && (r_jmp_count != '1))
        r_jmp_count <= r_jmp_count + 1'b1;
    end
  end

  assign ins_count = r_ins_count;
  assign jmp_count = r_jmp_count;
`else
  assign ins_count = '0;
  assign jmp_count = '0;
`endif

endmodule

// File: tb/tb_microc_ctrl.sv
// Directed self-checking bench for microc_ctrl (CNT_W=4); counter expectations follow MICROC_CTRL_PERF_EN.
module tb_microc_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMAX  = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       Opcode;
  logic             z;
  logic             s_inc, s_inm, we3, wez, halted, trap;
  logic [2:0]       Op;
  logic [CNT_W-1:0] ins_count, jmp_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned m_ins   = 0;
  int unsigned m_jmp   = 0;

  microc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .halted(halted), .trap(trap), .ins_count(ins_count), .jmp_count(jmp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic zz);
    Opcode = op;
    z      = zz;
    #1;
  endtask

  // Expected counter advance for one clock edge, saturating at 2^CNT_W-1.
  task automatic bump(input bit ins, input bit jmp);
    if (ins && m_ins < CMAX) m_ins++;
    if (jmp && m_jmp < CMAX) m_jmp++;
  endtask

  task automatic check_cnt(input string tag);
`ifdef MICROC_CTRL_PERF_EN
    check({tag, "_ins"}, ins_count, m_ins);
    check({tag, "_jmp"}, jmp_count, m_jmp);
`else
    check({tag, "_ins"}, ins_count, 0);
    check({tag, "_jmp"}, jmp_count, 0);
`endif
  endtask

  task automatic check_out(input string tag, input bit e_inc, input bit e_inm,
                           input bit e_we3, input bit e_wez, input int unsigned e_op);
    check({tag, "_s_inc"}, s_inc, e_inc);
    check({tag, "_s_inm"}, s_inm, e_inm);
    check({tag, "_we3"},   we3,   e_we3);
    check({tag, "_wez"},   wez,   e_wez);
    check({tag, "_Op"},    Op,    e_op);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_out("rst_pulse", 1, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    m_ins = 0;
    m_jmp = 0;
    check("rst_halted", halted, 0);
    check("rst_trap", trap, 0);
    check_cnt("rst");
  endtask

  initial begin
    reset  = 1'b0;
    Opcode = 6'b001010;
    z      = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_out("in_reset", 1, 0, 0, 0, 0);
      tick();
    end
    reset = 1'b1;
    check("post_rst_halted", halted, 0);
    check("post_rst_trap", trap, 0);
    check_cnt("post_rst");

    drive(6'b001101, 1'b0);
    check_out("alu101", 1, 0, 1, 1, 5);
    tick(); bump(1, 0);
    drive(6'b000110, 1'b0);
    check_out("li", 1, 1, 1, 0, 0);
    tick(); bump(1, 0);
    check_cnt("after_li");

    drive(6'b010001, 1'b1);
    check_out("jz_z1", 0, 0, 0, 0, 0);
    tick(); bump(1, 1);
    check_cnt("jz_z1");
    drive(6'b010001, 1'b0);
    check("jz_z0_s_inc", s_inc, 1);
    tick(); bump(1, 0);
    check_cnt("jz_z0");
    drive(6'b010010, 1'b0);
    check("jnz_z0_s_inc", s_inc, 0);
    tick(); bump(1, 1);
    drive(6'b010010, 1'b1);
    check("jnz_z1_s_inc", s_inc, 1);
    tick(); bump(1, 0);
    drive(6'b010000, 1'b1);
    check("j_z1_s_inc", s_inc, 0);
    tick(); bump(1, 1);
    drive(6'b010000, 1'b0);
    check_out("j_z0", 0, 0, 0, 0, 0);
    tick(); bump(1, 1);
    check_cnt("jumps");
    drive(6'b000000, 1'b0);
    check_out("nop", 1, 0, 0, 0, 0);
    tick(); bump(1, 0);

    drive(6'b010011, 1'b0);
    check_out("halt_op", 0, 0, 0, 0, 0);
    check("halt_pre", halted, 0);
    tick();
    check("halt_set", halted, 1);
    check("halt_notrap", trap, 0);
    check_cnt("halt");
    drive(6'b001111, 1'b1);
    check_out("in_halt_alu", 0, 0, 0, 0, 0);
    tick();
    check("halt_sticky", halted, 1);
    check_cnt("in_halt");
    do_reset();

    drive(6'b001001, 1'b0);
    check_out("run_again", 1, 0, 1, 1, 1);
    tick(); bump(1, 0);

    drive(6'b111111, 1'b0);
    check_out("illegal_ff", 0, 0, 0, 0, 0);
    check("trap_pre", trap, 0);
    tick();
    check("trap_set", trap, 1);
    check("trap_nohalt", halted, 0);
    check_cnt("trap");
    drive(6'b001101, 1'b1);
    check_out("in_trap_alu", 0, 0, 0, 0, 0);
    tick();
    check("trap_sticky", trap, 1);
    check_cnt("in_trap");
    do_reset();

    drive(6'b010100, 1'b0);
    check_out("illegal_010100", 0, 0, 0, 0, 0);
    tick();
    check("trap_010100", trap, 1);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      drive(6'b000000, 1'b0);
      tick(); bump(1, 0);
      if (i == 14) check_cnt("nop15");
    end
    check_cnt("nop20_sat");
    for (int i = 0; i < 17; i++) begin
      drive(6'b010000, 1'b0);
      tick(); bump(1, 1);
    end
    check_cnt("jmp_sat");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
